// File: rtl/vline_timing.sv
// Vertical timing generator: counts lines on each hline end-of-line tick and
// walks ACTIVE -> FRONT -> SYNC -> BACK, producing vsync_n, vblank, line, row and frame_start.
module vline_timing #(
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_tick,
  output logic       vsync_n,
  output logic       vblank,
  output logic [9:0] line,
  output logic [8:0] row,
  output logic       frame_start
);

  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] LINE_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] FRONT_START = 10'(V_ACTIVE);
  localparam logic [9:0] SYNC_START  = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] BACK_START  = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [8:0] ROW_HOLD    = 9'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [9:0] line_nxt;
  logic       wrap;

  always_comb begin
    wrap     = (line == LINE_LAST);
    line_nxt = wrap ? 10'd0 : line + 10'd1;
  end

  // Phase moves only when the next line lands exactly on a boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      ACTIVE:  if (line_nxt == FRONT_START) state_nxt = FRONT;
      FRONT:   if (line_nxt == SYNC_START)  state_nxt = SYNC;
      SYNC:    if (line_nxt == BACK_START)  state_nxt = BACK;
      BACK:    if (wrap)                    state_nxt = ACTIVE;
      default:                              state_nxt = ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line        <= '0;
      row         <= '0;
      state       <= ACTIVE;
      vsync_n     <= 1'b1;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else if (line_tick) begin
      line        <= line_nxt;
      state       <= state_nxt;
      vsync_n     <= (state_nxt != SYNC);
      vblank      <= (state_nxt != ACTIVE);
      row         <= (state_nxt == ACTIVE) ? line_nxt[8:0] : ROW_HOLD;
      frame_start <= wrap;
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule
